// File: rtl/instr_sequencer.sv
// Instruction fetch/issue stage for the 4-bit-address CPU.
// A host loads the program store while the sequencer is idle or halted. A start
// pulse then walks pc from index 0 and presents each word (opcode, address,
// operand) to the CPU with a valid/ready handshake. Execution stops at HLT or
// at the last store entry.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   ld_en/ld_addr/ld_data  program-store write port (honoured in IDLE/HALTED only)
//   start               single-cycle pulse, begins execution at index 0
//   cpu_ready           CPU accepts the presented word this cycle
//   opcode/address/myinput  registered instruction fields to the CPU
//   issue_valid         instruction fields are valid
//   pc                  index of the instruction fetched/presented
//   busy, done          FETCH/ISSUE and HALTED status flags
module instr_sequencer #(
    parameter int unsigned n   = 4,
    parameter int unsigned OPW = 4,
    parameter int unsigned DW  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_en,
    input  logic [n-1:0]          ld_addr,
    input  logic [OPW+n+DW-1:0]   ld_data,
    input  logic                  start,
    input  logic                  cpu_ready,
    output logic [OPW-1:0]        opcode,
    output logic [n-1:0]          address,
    output logic [DW-1:0]         myinput,
    output logic                  issue_valid,
    output logic [n-1:0]          pc,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned IW    = OPW + n + DW;
    localparam int unsigned DEPTH = 2 ** n;

    localparam logic [OPW-1:0] HLT     = '1;
    localparam logic [n-1:0]   LAST_PC = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALTED
    } state_t;

    state_t        state;
    logic [IW-1:0] store [DEPTH];
    logic [IW-1:0] fetch_word;
    logic          load_ok;

    // Loads are only honoured while no program is executing.
    assign load_ok    = (state == S_IDLE) || (state == S_HALTED);
    assign fetch_word = store[pc];

    // Program store: deliberately not reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (ld_en && load_ok) begin
            store[ld_addr] <= ld_data;
        end
    end

    // Sequencer FSM with registered outputs; busy/done track the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            opcode      <= '0;
            address     <= '0;
            myinput     <= '0;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state <= S_FETCH;
                        pc    <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    opcode      <= fetch_word[IW-1 -: OPW];
                    address     <= fetch_word[n+DW-1 -: n];
                    myinput     <= fetch_word[DW-1:0];
                    issue_valid <= 1'b1;
                    state       <= S_ISSUE;
                end
                S_ISSUE: begin
                    // Hold the presented word until the CPU takes it.
                    if (cpu_ready) begin
                        issue_valid <= 1'b0;
                        if (opcode == HLT || pc == LAST_PC) begin
                            state <= S_HALTED;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            pc    <= pc + n'(1);
                            state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction fetch/issue stage that sits directly upstream of the 4-bit-address CPU.
- Holds a small program store loaded from a host port.
- Steps a program counter through it and presents opcode, address and operand to the CPU with a valid/ready handshake.
- Stops at the HLT opcode (4'b1111) or at the end of the store, then reports done.

Parameters:
- n, 4, CPU address width; program store depth = 2**n entries.
- OPW, 4, opcode width.
- DW, 8, operand width.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-low reset.
- ld_en, input, 1, program-store write strobe.
- ld_addr, input, n, program-store write index.
- ld_data, input, OPW+n+DW, instruction word: [OPW+n+DW-1 -: OPW] opcode, next n bits address, low DW bits operand.
- start, input, 1, single-cycle pulse that begins execution at index 0.
- cpu_ready, input, 1, CPU accepts the presented instruction this cycle.
- opcode, output, OPW, registered opcode to the CPU.
- address, output, n, registered memory address to the CPU.
- myinput, output, DW, registered operand to the CPU.
- issue_valid, output, 1, opcode/address/myinput are valid.
- pc, output, n, index of the instruction currently fetched/presented.
- busy, output, 1, high in FETCH or ISSUE.
- done, output, 1, high in HALTED.

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE; pc=0; opcode=0; address=0; myinput=0; issue_valid=0; busy=0; done=0.
  - Program store contents are NOT cleared.
- States: IDLE, FETCH, ISSUE, HALTED.
- Loading: when ld_en=1 in IDLE or HALTED, store[ld_addr] <= ld_data at the clock edge. In FETCH/ISSUE, ld_en is ignored and the store is unchanged.
- IDLE/HALTED + start=1 -> FETCH with pc<=0 and done<=0. If ld_en and start occur in the same cycle, the write completes and execution starts; a write to index 0 is visible to the first fetch.
- FETCH: lasts 1 cycle.
  - Registers opcode/address/myinput from store[pc].
  - issue_valid<=1; next state ISSUE.
- ISSUE: outputs are held stable while cpu_ready=0 (unlimited stall). On a cycle with cpu_ready=1, the instruction is accepted and issue_valid<=0. The next state is chosen as:
  - opcode==4'b1111 -> HALTED (the HLT word is itself issued to the CPU).
  - else if pc==2**n-1 -> HALTED; pc holds at 2**n-1 (no wrap).
  - else pc<=pc+1 -> FETCH.
- Throughput: one instruction per 2 cycles when cpu_ready is held high. Latency from start to first issue_valid=1 is 2 edges.
- HALTED: done=1, busy=0, issue_valid=0. Outputs hold the last issued word. start restarts from index 0.
- start is ignored in FETCH/ISSUE.
- busy = (state==FETCH || state==ISSUE), decoded from registered state.
- Reset mid-operation: immediate return to IDLE, issue_valid drops asynchronously, and no partial instruction is held.

Test Plan:
- Reset values: assert rst=0 mid-cycle -> all outputs zero immediately, state IDLE. Release, then idle 5 cycles -> issue_valid=0, done=0.
- Basic program: load [0]={0101,0011,0x2A}, [1]={0110,0011,0x00}, [2]={1111,0000,0x00}; pulse start with cpu_ready=1.
  - Words presented in order with pc 0,1,2, each with issue_valid high for exactly 1 cycle, 2 cycles apart.
  - done=1 on the edge after the HLT word is accepted; the HLT word is issued.
- Stall: same program, cpu_ready=0 for 4 cycles during word 1 -> opcode=0110, address=0011, issue_valid=1 held constant for 4 cycles; pc stays 1; word 2 follows 2 cycles after cpu_ready=1.
- End of store: 16 words with no 1111, cpu_ready=1 -> 16 issues with pc 0..15, then HALTED with pc=15, no wrap to 0.
- Load lockout/restart:
  - ld_en to index 1 while busy -> store unchanged; the original word is issued.
  - After done, load the new word and pulse start -> the new word is issued at pc=1.
- Reset mid-run: rst=0 while in ISSUE at pc=3 -> issue_valid=0 and pc=0 immediately.
  - After release and start, execution restarts from pc=0 and the store contents are intact.
